// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Results are registered on the edge entering DONE and held until the next completion.
module seq_divider #(
  parameter int N_W = 16,
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_by_zero
);

  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [N_W-1:0] work_q;
  logic [D_W:0]   prem_q;
  logic [D_W-1:0] divisor_q;
  logic [CNT_W-1:0] cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [N_W-1:0] quotient_q;
  logic [D_W-1:0] remainder_q;
  logic           dbz_q;

  logic [D_W:0]   pr;
  logic           ge;
  logic [D_W:0]   prem_d;
  logic [N_W-1:0] work_d;
  logic           accept;

  // One restoring step: shift the next dividend bit into the partial remainder,
  // subtract the divisor when it fits, and shift the quotient bit into the work register.
  always_comb begin
    pr     = {prem_q[D_W-1:0], work_q[N_W-1]};
    ge     = (pr >= {1'b0, divisor_q});
    prem_d = ge ? (pr - {1'b0, divisor_q}) : pr;
    work_d = {work_q[N_W-2:0], ge};
  end

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      prem_q      <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            work_q    <= dividend;
            divisor_q <= divisor;
            prem_q    <= '0;
            cnt_q     <= CNT_W'(N_W - 1);
            if (divisor == '0) begin
              // Divide-by-zero skips RUN and completes on the very next cycle.
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= '0;
              dbz_q       <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          prem_q <= prem_d;
          work_q <= work_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= work_d;
            remainder_q <= prem_d[D_W-1:0];
            dbz_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider with hand-computed quotients, remainders and latencies.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int errors;
  int checks;
  int cyc;

  seq_divider #(.N_W(16), .D_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an operation; afterwards cyc=1 marks the first cycle after the start edge.
  task automatic startOp(input logic [15:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic waitDone();
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic checkResult(input string tag, input logic [15:0] eq, input logic [7:0] er,
                             input logic edbz, input int elat);
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " latency"}, 32'(cyc), 32'(elat));
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " quotient"}, 32'(quotient), 32'(eq));
    checkOutput({tag, " remainder"}, 32'(remainder), 32'(er));
    checkOutput({tag, " dbz"}, 32'(div_by_zero), 32'(edbz));
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [7:0] b,
                               input logic [15:0] eq, input logic [7:0] er, input logic edbz, input int elat);
    startOp(a, b);
    if (b != 8'd0) checkOutput({tag, " busy after start"}, 32'(busy), 32'd1);
    waitDone();
    checkResult(tag, eq, er, edbz, elat);
    tick();
    checkOutput({tag, " done pulse ends"}, 32'(done), 32'd0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset quotient", 32'(quotient), 32'd0);
    checkOutput("reset remainder", 32'(remainder), 32'd0);
    checkOutput("reset dbz", 32'(div_by_zero), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    applyStimulus("150/10", 16'd150, 8'd10, 16'd15, 8'd0, 1'b0, 17);
    applyStimulus("1000/7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17);
    applyStimulus("65535/1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 17);
    applyStimulus("5/255", 16'd5, 8'd255, 16'd0, 8'd5, 1'b0, 17);
    applyStimulus("1234/0", 16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1);
    applyStimulus("100/3", 16'd100, 8'd3, 16'd33, 8'd1, 1'b0, 17);

    // Start pulse during RUN must be ignored, then back-to-back launch from DONE.
    startOp(16'd200, 8'd9);
    repeat (4) begin
      tick();
      cyc++;
    end
    dividend = 16'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    tick();
    cyc++;
    start = 1'b0;
    checkOutput("ignored start busy", 32'(busy), 32'd1);
    waitDone();
    checkResult("200/9", 16'd22, 8'd2, 1'b0, 17);
    startOp(16'd100, 8'd3);
    checkOutput("b2b busy", 32'(busy), 32'd1);
    checkOutput("b2b done", 32'(done), 32'd0);
    checkOutput("b2b quotient hold", 32'(quotient), 32'd22);
    checkOutput("b2b remainder hold", 32'(remainder), 32'd2);
    waitDone();
    checkResult("b2b 100/3", 16'd33, 8'd1, 1'b0, 17);
    tick();

    // Asynchronous reset in the middle of RUN.
    startOp(16'd60000, 8'd13);
    repeat (7) tick();
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort quotient", 32'(quotient), 32'd0);
    checkOutput("abort remainder", 32'(remainder), 32'd0);
    checkOutput("abort dbz", 32'(div_by_zero), 32'd0);
    tick();
    tick();
    checkOutput("held reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    applyStimulus("post-reset 150/10", 16'd150, 8'd10, 16'd15, 8'd0, 1'b0, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider; the inverse of the team's 8x8 multiplier tile.
- Takes a 16-bit dividend (e.g. a multiplier product) and an 8-bit divisor, and returns a 16-bit quotient and an 8-bit remainder.
- Resolves one quotient bit per clock and uses a start/done handshake.
- Sits behind the tt_um_* top: {ui_in, uio_in} feed the operands and {uo_out, uio_out} carry the results.

Parameters:
- N_W, 16, dividend and quotient width; must satisfy N_W >= D_W.
- D_W, 8, divisor and remainder width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- dividend  in  N_W  captured on accepted start.
- divisor  in  D_W  captured on accepted start.
- busy  out  1  high while an operation is in progress (RUN state).
- done  out  1  one-cycle pulse; results valid from this cycle onward.
- quotient  out  N_W  registered result.
- remainder  out  D_W  registered result.
- div_by_zero  out  1  registered flag for the last completed operation.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; all working registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1:
  - Latch dividend into a working shift register.
  - Latch divisor; clear the partial remainder (D_W+1 bits); set the bit counter to N_W-1.
  - Next state RUN, or DONE if divisor==0.
- IDLE with start=0: remain in IDLE.
- RUN, each cycle:
  - pr = {partial_rem[D_W-1:0], work_msb}; shift work left.
  - If pr >= {1'b0, divisor}: partial_rem = pr - divisor and shift in quotient bit 1.
  - Otherwise: partial_rem = pr and shift in quotient bit 0.
  - The counter decrements. When the counter is 0 this cycle, the next state is DONE.
- RUN lasts exactly N_W cycles.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - Output registers are loaded on the edge entering DONE, so they are valid in the same cycle done=1.
  - Next state IDLE, unless start=1, in which case the new operands are accepted (back-to-back operation).
- Latency: start sampled on edge k; busy=1 for cycles k+1..k+N_W; done=1 in cycle k+N_W+1 (17 cycles for defaults).
- Divide-by-zero: no RUN phase; done=1 in cycle k+1; quotient = all ones, remainder = 0, div_by_zero = 1.
- For any non-zero divisor, div_by_zero=0 at completion.
- Output hold:
  - quotient, remainder and div_by_zero update only on the edge entering DONE.
  - They hold their values through IDLE and through the next RUN until the next completion.
- start in RUN is ignored; the operation in flight is unaffected and operand changes during RUN have no effect.
- Width rule: the partial remainder is D_W+1 bits so the compare does not overflow. The final remainder is always < divisor and fits D_W bits.
- Arithmetic is unsigned only.
- Reset mid-operation: immediate return to the reset values above; no done pulse for the aborted operation.

Test Plan:
- Reset, then start with dividend=150, divisor=10 -> done exactly 17 cycles after the start edge; quotient=15, remainder=0, div_by_zero=0. This round-trips the multiplier demo 15*10.
- dividend=1000, divisor=7 -> quotient=142, remainder=6.
- dividend=65535, divisor=1 -> quotient=65535, remainder=0. Then dividend=5, divisor=255 -> quotient=0, remainder=5.
- dividend=1234, divisor=0 -> done 1 cycle after start; quotient=16'hFFFF, remainder=0, div_by_zero=1. A following 100/3 -> quotient=33, remainder=1, div_by_zero=0.
- Start 200/9. Pulse start with 50/5 at cycle 5 of RUN -> ignored; result is quotient=22, remainder=2. Start held high in DONE -> second operation launches back-to-back with no IDLE cycle.
- Start 60000/13, assert rst_n=0 at cycle 8 of RUN -> busy, done and all outputs go to 0 immediately. After release, a 150/10 run completes normally with quotient=15, remainder=0.
